// File: rtl/mmio_timer_gpio.sv
// MMIO responder on the core's data-memory bus: LED register, compare timer
// with interrupt flag, and a free-running cycle counter in a 32-byte window.
module mmio_timer_gpio #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_1000,
    parameter int unsigned LED_W     = 18
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      addr,
    input  logic [31:0]      dataW,
    input  logic             MemRW,
    output logic [31:0]      dataR,
    output logic             hit,
    output logic [LED_W-1:0] LED_out,
    output logic             irq
);

    // Bus semantics: there is no handshake. A store commits on the rising edge
    // where hit & MemRW is high; a load is a pure combinational read of the
    // selected register in the same cycle and never alters state.
    localparam logic [2:0] REG_LED    = 3'd0;
    localparam logic [2:0] REG_CTRL   = 3'd1;
    localparam logic [2:0] REG_CMP    = 3'd2;
    localparam logic [2:0] REG_CNT    = 3'd3;
    localparam logic [2:0] REG_STATUS = 3'd4;
    localparam logic [2:0] REG_CYCLE  = 3'd5;

    logic [LED_W-1:0] led_q;
    logic [2:0]       ctrl_q;
    logic [31:0]      cmp_q;
    logic [31:0]      cnt_q;
    logic [31:0]      cycle_q;
    logic             match_q;
    logic             irq_q;

    logic [2:0]       reg_sel;
    logic             wr_en;
    logic             cnt_match;
    logic [2:0]       ctrl_d;
    logic [31:0]      cnt_d;
    logic             match_d;
    logic             unused_addr_lsbs;

    assign hit              = (addr[31:5] == BASE_ADDR[31:5]);
    assign reg_sel          = addr[4:2];
    assign wr_en            = hit & MemRW;
    assign unused_addr_lsbs = ^addr[1:0];

    // Compare uses pre-edge CNT/CMP, so a CMP store only matters next cycle.
    assign cnt_match = ctrl_q[0] && (cnt_q == cmp_q);

    always_comb begin
        ctrl_d = ctrl_q;
        if (wr_en && reg_sel == REG_CTRL) begin
            ctrl_d = dataW[2:0];
        end
    end

    // A CPU store to CNT beats both reload and increment.
    always_comb begin
        cnt_d = cnt_q;
        if (wr_en && reg_sel == REG_CNT) begin
            cnt_d = dataW;
        end else if (cnt_match) begin
            cnt_d = ctrl_q[1] ? 32'd0 : cnt_q + 32'd1;
        end else if (ctrl_q[0]) begin
            cnt_d = cnt_q + 32'd1;
        end
    end

    // A timer match is checked first so it wins over a same-cycle W1C clear.
    always_comb begin
        match_d = match_q;
        if (cnt_match) begin
            match_d = 1'b1;
        end else if (wr_en && reg_sel == REG_STATUS && dataW[0]) begin
            match_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            led_q   <= '0;
            ctrl_q  <= '0;
            cmp_q   <= '0;
            cnt_q   <= '0;
            cycle_q <= '0;
            match_q <= 1'b0;
            irq_q   <= 1'b0;
        end else begin
            if (wr_en && reg_sel == REG_LED) begin
                led_q <= dataW[LED_W-1:0];
            end
            if (wr_en && reg_sel == REG_CMP) begin
                cmp_q <= dataW;
            end
            ctrl_q  <= ctrl_d;
            cnt_q   <= cnt_d;
            match_q <= match_d;
            cycle_q <= cycle_q + 32'd1;
            irq_q   <= match_d & ctrl_d[2];
        end
    end

    always_comb begin
        dataR = 32'd0;
        if (hit) begin
            case (reg_sel)
                REG_LED:    dataR = 32'(led_q);
                REG_CTRL:   dataR = {29'd0, ctrl_q};
                REG_CMP:    dataR = cmp_q;
                REG_CNT:    dataR = cnt_q;
                REG_STATUS: dataR = {31'd0, match_q};
                REG_CYCLE:  dataR = cycle_q;
                default:    dataR = 32'd0;
            endcase
        end
    end

    assign LED_out = led_q;
    assign irq     = irq_q;

endmodule

// File: tb/tb_mmio_timer_gpio.sv
// Self-checking bench for mmio_timer_gpio: register map, LED, one-shot and
// auto-reload timer, store priority, and asynchronous reset.
module tb_mmio_timer_gpio;

    localparam logic [31:0] BASE   = 32'h0000_1000;
    localparam logic [31:0] A_LED  = BASE + 32'h00;
    localparam logic [31:0] A_CTRL = BASE + 32'h04;
    localparam logic [31:0] A_CMP  = BASE + 32'h08;
    localparam logic [31:0] A_CNT  = BASE + 32'h0C;
    localparam logic [31:0] A_STAT = BASE + 32'h10;
    localparam logic [31:0] A_CYC  = BASE + 32'h14;

    logic        clk   = 1'b0;
    logic        rst   = 1'b1;
    logic [31:0] addr  = '0;
    logic [31:0] dataW = '0;
    logic        MemRW = 1'b0;
    logic [31:0] dataR;
    logic        hit;
    logic [17:0] LED_out;
    logic        irq;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] exp_q[$];
    logic [31:0] got;
    logic [31:0] e;
    logic [31:0] tb_cycles;

    mmio_timer_gpio #(.BASE_ADDR(BASE), .LED_W(18)) dut (
        .clk(clk), .rst(rst), .addr(addr), .dataW(dataW), .MemRW(MemRW),
        .dataR(dataR), .hit(hit), .LED_out(LED_out), .irq(irq)
    );

    // clock/reset block
    always #5 clk = ~clk;

    always @(posedge clk or posedge rst) begin
        if (rst) tb_cycles <= '0;
        else     tb_cycles <= tb_cycles + 32'd1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish, got=timeout exp=finish");
        $fatal(1);
    end

    // driver tasks
    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        addr = a; dataW = d; MemRW = 1'b1;
        @(posedge clk);
        #1;
        MemRW = 1'b0; dataW = '0;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d);
        addr = a; MemRW = 1'b0;
        #1;
        d = dataR;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        #2;
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back(32'd0);
            rd(BASE + 32'(4 * i), got); e = exp_q.pop_front(); n_tests++;
            if (got !== e) begin n_fail++; $display("FAIL reset_reg%0d got=%h exp=%h", i, got, e); end
        end
        n_tests++;
        if (LED_out !== 18'd0) begin n_fail++; $display("FAIL reset_led got=%h exp=0", LED_out); end
        n_tests++;
        if (irq !== 1'b0) begin n_fail++; $display("FAIL reset_irq got=%b exp=0", irq); end
        @(negedge clk) rst = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        exp_q.push_back(32'd5);
        rd(A_CYC, got); e = exp_q.pop_front(); n_tests++;
        if (got !== e) begin n_fail++; $display("FAIL cycle_count got=%0d exp=%0d", got, e); end
    endtask

    task automatic test_led;
        logic [31:0] d;
        wr(A_LED, 32'hFFFF_FFFF);
        n_tests++;
        if (LED_out !== 18'h3FFFF) begin n_fail++; $display("FAIL led_out_all got=%h exp=3ffff", LED_out); end
        exp_q.push_back(32'h0003_FFFF);
        rd(A_LED, got); e = exp_q.pop_front(); n_tests++;
        if (got !== e) begin n_fail++; $display("FAIL led_read got=%h exp=%h", got, e); end
        wr(32'h0000_2000, 32'h0);
        n_tests++;
        if (LED_out !== 18'h3FFFF) begin n_fail++; $display("FAIL led_miss_store got=%h exp=3ffff", LED_out); end
        exp_q.push_back(32'h0);
        rd(32'h0000_2000, got); e = exp_q.pop_front(); n_tests++;
        if (got !== e || hit !== 1'b0) begin n_fail++; $display("FAIL miss_read got=%h hit=%b exp=%h hit=0", got, hit, e); end
        for (int i = 0; i < 3; i++) begin
            d = $urandom;
            wr(A_LED, d);
            exp_q.push_back(d & 32'h0003_FFFF);
            rd(A_LED, got); e = exp_q.pop_front(); n_tests++;
            if (got !== e || LED_out !== e[17:0]) begin n_fail++; $display("FAIL led_rand got=%h pin=%h exp=%h", got, LED_out, e); end
        end
        wr(A_CYC, 32'hDEAD_BEEF);
        exp_q.push_back(tb_cycles);
        rd(A_CYC, got); e = exp_q.pop_front(); n_tests++;
        if (got !== e) begin n_fail++; $display("FAIL cycle_ro got=%h exp=%h", got, e); end
        wr(BASE + 32'h18, 32'hFFFF_FFFF);
        exp_q.push_back(32'h0);
        rd(BASE + 32'h18, got); e = exp_q.pop_front(); n_tests++;
        if (got !== e) begin n_fail++; $display("FAIL reserved_18 got=%h exp=%h", got, e); end
    endtask

    task automatic test_one_shot;
        wr(A_CMP, 32'd5);
        wr(A_CNT, 32'd0);
        wr(A_CTRL, 32'h5);
        exp_q.push_back(32'h5);
        rd(A_CTRL, got); e = exp_q.pop_front(); n_tests++;
        if (got !== e) begin n_fail++; $display("FAIL ctrl_read got=%h exp=%h", got, e); end
        for (int i = 1; i <= 6; i++) begin
            @(posedge clk);
            #1;
            exp_q.push_back(32'(i));
            exp_q.push_back((i == 6) ? 32'd1 : 32'd0);
            rd(A_CNT, got); e = exp_q.pop_front(); n_tests++;
            if (got !== e) begin n_fail++; $display("FAIL oneshot_cnt got=%0d exp=%0d", got, e); end
            rd(A_STAT, got); e = exp_q.pop_front(); n_tests++;
            if (got !== e || irq !== e[0]) begin n_fail++; $display("FAIL oneshot_match got=%h irq=%b exp=%h", got, irq, e); end
        end
        wr(A_STAT, 32'h1);
        exp_q.push_back(32'd7);
        exp_q.push_back(32'd0);
        rd(A_CNT, got); e = exp_q.pop_front(); n_tests++;
        if (got !== e) begin n_fail++; $display("FAIL oneshot_continue got=%0d exp=%0d", got, e); end
        rd(A_STAT, got); e = exp_q.pop_front(); n_tests++;
        if (got !== e || irq !== 1'b0) begin n_fail++; $display("FAIL oneshot_clear got=%h irq=%b exp=%h", got, irq, e); end
        wr(A_CTRL, 32'h0);
    endtask

    task automatic test_auto_reload;
        logic [31:0] m_cnt;
        logic [31:0] m_match;
        wr(A_CMP, 32'd3);
        wr(A_CNT, 32'd0);
        wr(A_STAT, 32'h1);
        wr(A_CTRL, 32'h3);
        m_cnt = 0; m_match = 0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk);
            #1;
            if (m_cnt == 32'd3) begin m_match = 1; m_cnt = 0; end
            else m_cnt = m_cnt + 1;
            exp_q.push_back(m_cnt);
            exp_q.push_back(m_match);
            rd(A_CNT, got); e = exp_q.pop_front(); n_tests++;
            if (got !== e) begin n_fail++; $display("FAIL reload_cnt step=%0d got=%0d exp=%0d", k, got, e); end
            rd(A_STAT, got); e = exp_q.pop_front(); n_tests++;
            if (got !== e || irq !== 1'b0) begin n_fail++; $display("FAIL reload_match step=%0d got=%h irq=%b exp=%h", k, got, irq, e); end
        end
        repeat (3) @(posedge clk);
        #1;
        wr(A_STAT, 32'h1);
        exp_q.push_back(32'd0);
        exp_q.push_back(32'd1);
        rd(A_CNT, got); e = exp_q.pop_front(); n_tests++;
        if (got !== e) begin n_fail++; $display("FAIL set_vs_clear_cnt got=%0d exp=%0d", got, e); end
        rd(A_STAT, got); e = exp_q.pop_front(); n_tests++;
        if (got !== e) begin n_fail++; $display("FAIL set_vs_clear got=%h exp=%h", got, e); end
        wr(A_STAT, 32'h0);
        exp_q.push_back(32'd1);
        rd(A_STAT, got); e = exp_q.pop_front(); n_tests++;
        if (got !== e) begin n_fail++; $display("FAIL w0_no_effect got=%h exp=%h", got, e); end
        wr(A_STAT, 32'h1);
        exp_q.push_back(32'd0);
        rd(A_STAT, got); e = exp_q.pop_front(); n_tests++;
        if (got !== e) begin n_fail++; $display("FAIL w1c_clear got=%h exp=%h", got, e); end
        wr(A_CTRL, 32'h0);
    endtask

    task automatic test_priority;
        wr(A_STAT, 32'h1);
        wr(A_CMP, 32'd10);
        wr(A_CNT, 32'd10);
        wr(A_CTRL, 32'h3);
        exp_q.push_back(32'd10);
        rd(A_CNT, got); e = exp_q.pop_front(); n_tests++;
        if (got !== e) begin n_fail++; $display("FAIL prio_setup got=%0d exp=%0d", got, e); end
        wr(A_CNT, 32'h100);
        exp_q.push_back(32'h100);
        exp_q.push_back(32'd1);
        rd(A_CNT, got); e = exp_q.pop_front(); n_tests++;
        if (got !== e) begin n_fail++; $display("FAIL prio_cnt got=%h exp=%h", got, e); end
        rd(A_STAT, got); e = exp_q.pop_front(); n_tests++;
        if (got !== e) begin n_fail++; $display("FAIL prio_match got=%h exp=%h", got, e); end
        @(posedge clk);
        #1;
        exp_q.push_back(32'h101);
        rd(A_CNT, got); e = exp_q.pop_front(); n_tests++;
        if (got !== e) begin n_fail++; $display("FAIL prio_next got=%h exp=%h", got, e); end
        wr(A_CTRL, 32'h0);
        wr(A_STAT, 32'h1);
    endtask

    task automatic test_async_reset;
        wr(A_LED, 32'h0000_0ABC);
        wr(A_CMP, 32'd5);
        wr(A_CNT, 32'd0);
        wr(A_CTRL, 32'h5);
        repeat (7) @(posedge clk);
        #1;
        exp_q.push_back(32'd7);
        exp_q.push_back(32'd1);
        rd(A_CNT, got); e = exp_q.pop_front(); n_tests++;
        if (got !== e) begin n_fail++; $display("FAIL pre_rst_cnt got=%0d exp=%0d", got, e); end
        rd(A_STAT, got); e = exp_q.pop_front(); n_tests++;
        if (got !== e || irq !== 1'b1) begin n_fail++; $display("FAIL pre_rst_match got=%h irq=%b exp=%h irq=1", got, irq, e); end
        rst = 1'b1;
        #1;
        n_tests++;
        if (irq !== 1'b0 || LED_out !== 18'd0) begin n_fail++; $display("FAIL rst_pins irq=%b led=%h exp=0", irq, LED_out); end
        exp_q.push_back(32'd0);
        exp_q.push_back(32'd0);
        exp_q.push_back(32'd0);
        rd(A_CNT, got); e = exp_q.pop_front(); n_tests++;
        if (got !== e) begin n_fail++; $display("FAIL rst_cnt got=%0d exp=%0d", got, e); end
        rd(A_STAT, got); e = exp_q.pop_front(); n_tests++;
        if (got !== e) begin n_fail++; $display("FAIL rst_match got=%h exp=%h", got, e); end
        rd(A_CYC, got); e = exp_q.pop_front(); n_tests++;
        if (got !== e) begin n_fail++; $display("FAIL rst_cycle got=%0d exp=%0d", got, e); end
        @(negedge clk) rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        exp_q.push_back(32'd3);
        exp_q.push_back(32'd0);
        rd(A_CYC, got); e = exp_q.pop_front(); n_tests++;
        if (got !== e) begin n_fail++; $display("FAIL cycle_restart got=%0d exp=%0d", got, e); end
        rd(A_CNT, got); e = exp_q.pop_front(); n_tests++;
        if (got !== e) begin n_fail++; $display("FAIL cnt_after_rst got=%0d exp=%0d", got, e); end
    endtask

    initial begin
        test_reset();
        test_led();
        test_one_shot();
        test_auto_reload();
        test_priority();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
